// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Fetch sequencer for an external program counter. Reads the instruction at
//   pc_q over a req/ack memory port, offers it to the execute stage over a
//   valid/ready handshake, then tells the PC to load a target (ld_pc + a) or
//   to increment (in_pc). A small return-address stack backs CALL/RET.
//
//   The PC register commits on the falling edge, so a strobe raised here for
//   one cycle is already visible on pc_q at the following rising edge.
//
// Ports
//   clk, rst           clock (posedge) and synchronous active-high reset
//   run                leave IDLE and start fetching
//   pc_q               current PC value
//   ld_pc, in_pc, a    PC load strobe, PC increment strobe, PC load value
//   mem_req, mem_addr  instruction read request and address
//   mem_ack, mem_rdata read done and instruction word (valid with mem_ack)
//   ir, ir_valid       registered instruction and its valid flag
//   ir_ready           execute stage accepts ir
//   flag_z             zero flag for JZ
//   halted             high while IDLE
//   stk_err            sticky return-stack overflow/underflow
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int         IW        = 16,
    parameter int         STK_DEPTH = 4,
    parameter logic [7:0] RESET_VEC = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [7:0]    pc_q,
    output logic          ld_pc,
    output logic          in_pc,
    output logic [7:0]    a,
    output logic          mem_req,
    output logic [7:0]    mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic [IW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          flag_z,
    output logic          halted,
    output logic          stk_err
);

    localparam int IX_W = $clog2(STK_DEPTH);
    localparam int SP_W = IX_W + 1;

    localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STK_DEPTH);

    localparam logic [2:0] ST_RST_LOAD = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_FETCH    = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_UPDATE   = 3'd4;

    localparam logic [3:0] OP_HALT = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    logic [2:0]      state_r, state_nxt_s;
    logic            ld_pc_r, ld_pc_nxt_s;
    logic            in_pc_r, in_pc_nxt_s;
    logic [7:0]      a_r, a_nxt_s;
    logic [IW-1:0]   ir_r, ir_nxt_s;
    logic [7:0]      mem_addr_r, mem_addr_nxt_s;
    logic            mem_req_r, ir_valid_r, halted_r;
    logic            stk_err_r, stk_err_nxt_s;
    logic [SP_W-1:0] sp_r, sp_nxt_s;
    logic [7:0]      stack_r [STK_DEPTH];
    logic            push_s;
    logic [7:0]      push_val_s;
    logic [IX_W-1:0] pop_idx_s;
    logic [3:0]      opcode_s;
    logic [7:0]      target_s;

    assign opcode_s   = ir_r[IW-1:IW-4];
    assign target_s   = ir_r[7:0];
    assign push_val_s = pc_q + 8'd1;
    // sp is never 0 when popping, so the low bits minus one wrap to the top entry correctly
    assign pop_idx_s  = sp_r[IX_W-1:0] - IX_W'(1);

    assign ld_pc    = ld_pc_r;
    assign in_pc    = in_pc_r;
    assign a        = a_r;
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign ir       = ir_r;
    assign ir_valid = ir_valid_r;
    assign halted   = halted_r;
    assign stk_err  = stk_err_r;

    // Next-state, strobe and stack decisions. The UPDATE action is decided on
    // the ir_ready edge so the strobes come straight from flops during UPDATE.
    always_comb begin
        state_nxt_s    = state_r;
        ld_pc_nxt_s    = 1'b0;
        in_pc_nxt_s    = 1'b0;
        a_nxt_s        = a_r;
        ir_nxt_s       = ir_r;
        mem_addr_nxt_s = mem_addr_r;
        sp_nxt_s       = sp_r;
        push_s         = 1'b0;
        stk_err_nxt_s  = stk_err_r;
        case (state_r)
            ST_RST_LOAD: begin
                state_nxt_s = ST_IDLE;
                ld_pc_nxt_s = 1'b1;
                a_nxt_s     = RESET_VEC;
            end
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s    = ST_FETCH;
                    mem_addr_nxt_s = pc_q;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_nxt_s    = mem_rdata;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (ir_ready) begin
                    state_nxt_s = ST_UPDATE;
                    case (opcode_s)
                        OP_JMP: begin
                            ld_pc_nxt_s = 1'b1;
                            a_nxt_s     = target_s;
                        end
                        OP_JZ: begin
                            if (flag_z) begin
                                ld_pc_nxt_s = 1'b1;
                                a_nxt_s     = target_s;
                            end else begin
                                in_pc_nxt_s = 1'b1;
                            end
                        end
                        OP_CALL: begin
                            // full stack: refuse the call and fall through
                            if (sp_r == SP_FULL) begin
                                stk_err_nxt_s = 1'b1;
                                in_pc_nxt_s   = 1'b1;
                            end else begin
                                push_s      = 1'b1;
                                sp_nxt_s    = sp_r + SP_ONE;
                                ld_pc_nxt_s = 1'b1;
                                a_nxt_s     = target_s;
                            end
                        end
                        OP_RET: begin
                            // empty stack: nothing to return to, fall through
                            if (sp_r == SP_ZERO) begin
                                stk_err_nxt_s = 1'b1;
                                in_pc_nxt_s   = 1'b1;
                            end else begin
                                sp_nxt_s    = sp_r - SP_ONE;
                                ld_pc_nxt_s = 1'b1;
                                a_nxt_s     = stack_r[pop_idx_s];
                            end
                        end
                        OP_HALT: begin
                            ld_pc_nxt_s = 1'b0;
                        end
                        default: begin
                            in_pc_nxt_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_UPDATE: begin
                // pc_q already reflects the UPDATE strobe at this edge
                if (opcode_s == OP_HALT) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s    = ST_FETCH;
                    mem_addr_nxt_s = pc_q;
                end
            end
            default: begin
                state_nxt_s = ST_RST_LOAD;
            end
        endcase
    end

    // State, registered outputs and return stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RST_LOAD;
            ld_pc_r    <= 1'b0;
            in_pc_r    <= 1'b0;
            a_r        <= RESET_VEC;
            ir_r       <= {IW{1'b0}};
            mem_addr_r <= 8'h00;
            mem_req_r  <= 1'b0;
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            stk_err_r  <= 1'b0;
            sp_r       <= SP_ZERO;
            for (int i = 0; i < STK_DEPTH; i++) begin
                stack_r[i] <= 8'h00;
            end
        end else begin
            state_r    <= state_nxt_s;
            ld_pc_r    <= ld_pc_nxt_s;
            in_pc_r    <= in_pc_nxt_s;
            a_r        <= a_nxt_s;
            ir_r       <= ir_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            mem_req_r  <= (state_nxt_s == ST_FETCH);
            ir_valid_r <= (state_nxt_s == ST_ISSUE);
            halted_r   <= (state_nxt_s == ST_IDLE);
            stk_err_r  <= stk_err_nxt_s;
            sp_r       <= sp_nxt_s;
            if (push_s) begin
                stack_r[sp_r[IX_W-1:0]] <= push_val_s;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Directed bench for pc_fetch_ctrl. A behavioural PC (falling-edge commit),
//   an instruction memory with fixed ack latency and an execute-stage ready
//   responder surround the DUT. Stimulus pushes the expected strobe/request/
//   issue events into a queue; a monitor pops and compares each event the DUT
//   produces.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [7:0] RV = 8'h00;

    localparam logic [1:0] K_LD  = 2'd0;
    localparam logic [1:0] K_INC = 2'd1;
    localparam logic [1:0] K_REQ = 2'd2;
    localparam logic [1:0] K_ISS = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, run, flag_z;
    logic [7:0]  pc_q;
    logic        ld_pc, in_pc, mem_req, mem_ack, ir_valid, ir_ready, halted, stk_err;
    logic [7:0]  a, mem_addr;
    logic [15:0] mem_rdata, ir;

    logic [15:0] imem [256];
    logic [7:0]  pc_r = 8'h5A;
    ev_t         exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 2;
    bit          block_ack = 1'b0;

    always #5 clk = ~clk;

    assign pc_q = pc_r;

    pc_fetch_ctrl #(.IW(16), .STK_DEPTH(4), .RESET_VEC(RV)) dut (
        .clk(clk), .rst(rst), .run(run), .pc_q(pc_q),
        .ld_pc(ld_pc), .in_pc(in_pc), .a(a),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .flag_z(flag_z), .halted(halted), .stk_err(stk_err)
    );

    // Program counter register: commits strobes on the falling edge
    always @(negedge clk) begin
        if (ld_pc) pc_r <= a;
        else if (in_pc) pc_r <= pc_r + 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic e_ld(input logic [7:0] v);  exp_q.push_back({K_LD,  16'h0000, v}); endtask
    task automatic e_inc(input logic [7:0] v); exp_q.push_back({K_INC, 16'h0000, v}); endtask
    task automatic e_req(input logic [7:0] v); exp_q.push_back({K_REQ, 16'h0000, v}); endtask
    task automatic e_iss(input logic [15:0] w, input logic [7:0] wt);
        exp_q.push_back({K_ISS, wt, w});
    endtask

    task automatic got(input logic [1:0] k, input logic [23:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event actual=%0d:%h required=none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e !== {k, v}) begin
                errors++;
                $display("FAIL event actual=%0d:%h required=%0d:%h", k, v, e.kind, e.val);
            end
        end
    endtask

    function automatic int rdy_dly(input logic [15:0] w);
        return (w == 16'hC040) ? 3 : 0;
    endfunction

    // Monitor: turns DUT activity into events and checks them against the queue
    initial begin : monitor
        logic        prev_req;
        logic        inv;
        logic [15:0] first_ir;
        int          vcnt;
        prev_req = 1'b0; inv = 1'b0; first_ir = 16'h0; vcnt = 0;
        forever begin
            @(negedge clk);
            if (ld_pc === 1'b1 || in_pc === 1'b1) chk("strobe_excl", {31'd0, ld_pc & in_pc}, 32'd0);
            if (ld_pc === 1'b1) got(K_LD, {16'h0000, a});
            if (in_pc === 1'b1) got(K_INC, {16'h0000, pc_q});
            if (mem_req === 1'b1 && !prev_req) got(K_REQ, {16'h0000, mem_addr});
            prev_req = (mem_req === 1'b1);
            if (ir_valid === 1'b1) begin
                if (!inv) begin
                    first_ir = ir; vcnt = 0; inv = 1'b1;
                end else begin
                    chk("ir_stable", {16'h0, ir}, {16'h0, first_ir});
                end
                if (ir_ready) begin
                    got(K_ISS, {8'(vcnt), ir});
                    inv = 1'b0;
                end else begin
                    vcnt++;
                end
            end else begin
                inv = 1'b0;
            end
        end
    end

    // Instruction memory: ack in the lat-th cycle of a request
    initial begin : mem_model
        int mcnt;
        mcnt = 0; mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk); #1;
            if (!block_ack) begin
                if (mem_req === 1'b1) begin
                    if (mcnt + 1 >= lat) begin
                        mem_ack = 1'b1; mem_rdata = imem[mem_addr]; mcnt = 0;
                    end else begin
                        mem_ack = 1'b0; mem_rdata = 16'hDEAD; mcnt++;
                    end
                end else begin
                    mem_ack = 1'b0; mem_rdata = 16'hDEAD; mcnt = 0;
                end
            end
        end
    end

    // Execute stage: ready after rdy_dly(ir) cycles of valid
    initial begin : exec_model
        int rcnt;
        rcnt = 0; ir_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ir_valid === 1'b1) begin
                if (rcnt >= rdy_dly(ir)) ir_ready = 1'b1;
                else begin ir_ready = 1'b0; rcnt++; end
            end else begin
                ir_ready = 1'b0; rcnt = 0;
            end
        end
    end

    task automatic go(input string nm);
        int n = 0;
        run = 1'b1;
        do begin @(posedge clk); #2; n++; end while (mem_req !== 1'b1 && n < 20);
        run = 1'b0;
        chk({nm, "_start"}, {31'd0, mem_req}, 32'd1);
    endtask

    task automatic wait_fetch_done();
        int n = 0;
        while (mem_req === 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    endtask

    task automatic end_seg(input string nm, input logic [7:0] pc_exp);
        int n = 0;
        while (halted !== 1'b1 && n < 500) begin @(posedge clk); #2; n++; end
        chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
        repeat (4) @(posedge clk);
        #2;
        chk({nm, "_pc_held"}, {24'd0, pc_q}, {24'd0, pc_exp});
        chk({nm, "_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin : stim
        rst = 1'b1; run = 1'b0; flag_z = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 16'hB000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ld_pc", {31'd0, ld_pc}, 32'd0);
        chk("rst_in_pc", {31'd0, in_pc}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_a", {24'd0, a}, {24'd0, RV});
        chk("rst_ir", {16'd0, ir}, 32'd0);
        chk("rst_stk_err", {31'd0, stk_err}, 32'd0);

        // plain fetch, delayed JMP accept, JZ not taken, HALT
        imem[8'h00] = 16'h1000; imem[8'h01] = 16'hC040;
        imem[8'h40] = 16'hD080; imem[8'h41] = 16'hB000;
        e_ld(8'h00); e_req(8'h00); e_iss(16'h1000, 8'd0); e_inc(8'h00);
        e_req(8'h01); e_iss(16'hC040, 8'd3); e_ld(8'h40);
        e_req(8'h40); e_iss(16'hD080, 8'd0); e_inc(8'h40);
        e_req(8'h41); e_iss(16'hB000, 8'd0);
        run = 1'b1; rst = 1'b0;
        go("seg_a");
        end_seg("seg_a", 8'h41);
        chk("seg_a_ir", {16'd0, ir}, 32'h0000B000);

        // JZ taken, CALL/RET round trip
        imem[8'h41] = 16'hD080; imem[8'h80] = 16'hC010; imem[8'h10] = 16'hE020;
        imem[8'h20] = 16'hF000; imem[8'h11] = 16'hB000;
        flag_z = 1'b1;
        e_req(8'h41); e_iss(16'hD080, 8'd0); e_ld(8'h80);
        e_req(8'h80); e_iss(16'hC010, 8'd0); e_ld(8'h10);
        e_req(8'h10); e_iss(16'hE020, 8'd0); e_ld(8'h20);
        e_req(8'h20); e_iss(16'hF000, 8'd0); e_ld(8'h11);
        e_req(8'h11); e_iss(16'hB000, 8'd0);
        go("seg_b");
        end_seg("seg_b", 8'h11);
        chk("seg_b_stk_err", {31'd0, stk_err}, 32'd0);

        // five nested CALLs: the fifth overflows; RET returns the last pushed
        imem[8'h11] = 16'hE030; imem[8'h30] = 16'hE050; imem[8'h50] = 16'hE060;
        imem[8'h60] = 16'hE070; imem[8'h70] = 16'hE090; imem[8'h71] = 16'hF000;
        imem[8'h61] = 16'hB000;
        e_req(8'h11); e_iss(16'hE030, 8'd0); e_ld(8'h30);
        e_req(8'h30); e_iss(16'hE050, 8'd0); e_ld(8'h50);
        e_req(8'h50); e_iss(16'hE060, 8'd0); e_ld(8'h60);
        e_req(8'h60); e_iss(16'hE070, 8'd0); e_ld(8'h70);
        e_req(8'h70); e_iss(16'hE090, 8'd0); e_inc(8'h70);
        e_req(8'h71); e_iss(16'hF000, 8'd0); e_ld(8'h61);
        e_req(8'h61); e_iss(16'hB000, 8'd0);
        go("seg_c");
        end_seg("seg_c", 8'h61);
        chk("seg_c_stk_err", {31'd0, stk_err}, 32'd1);

        // reset while a request is outstanding; late ack must be ignored
        block_ack = 1'b1; mem_ack = 1'b0; mem_rdata = 16'hF00D;
        e_req(8'h61); e_ld(RV);
        go("seg_d");
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rst_drops_req", {31'd0, mem_req}, 32'd0);
        chk("rst_no_strobe", {31'd0, ld_pc}, 32'd0);
        mem_ack = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_load_strobe", {31'd0, ld_pc}, 32'd1);
        chk("rst_load_a", {24'd0, a}, {24'd0, RV});
        @(posedge clk); #2;
        mem_ack = 1'b0; block_ack = 1'b0;
        chk("late_ack_ir", {16'd0, ir}, 32'd0);
        chk("late_ack_no_valid", {31'd0, ir_valid}, 32'd0);
        chk("seg_d_halted", {31'd0, halted}, 32'd1);
        chk("seg_d_stk_err", {31'd0, stk_err}, 32'd0);
        chk("seg_d_pc", {24'd0, pc_q}, {24'd0, RV});
        chk("seg_d_drained", exp_q.size(), 32'd0);

        // RET on the emptied stack, CALL at 0xFF returns to 0x00
        imem[8'h00] = 16'hC0F0; imem[8'hF0] = 16'hF000; imem[8'hF1] = 16'hC0FE;
        imem[8'hFE] = 16'h1111; imem[8'hFF] = 16'hE0A0; imem[8'hA0] = 16'hF000;
        e_req(8'h00); e_iss(16'hC0F0, 8'd0); e_ld(8'hF0);
        e_req(8'hF0); e_iss(16'hF000, 8'd0); e_inc(8'hF0);
        e_req(8'hF1); e_iss(16'hC0FE, 8'd0); e_ld(8'hFE);
        e_req(8'hFE); e_iss(16'h1111, 8'd0); e_inc(8'hFE);
        e_req(8'hFF); e_iss(16'hE0A0, 8'd0); e_ld(8'hA0);
        e_req(8'hA0); e_iss(16'hF000, 8'd0); e_ld(8'h00);
        e_req(8'h00); e_iss(16'hB000, 8'd0);
        go("seg_e");
        wait_fetch_done();
        imem[8'h00] = 16'hB000;
        end_seg("seg_e", 8'h00);
        chk("seg_e_stk_err", {31'd0, stk_err}, 32'd1);

        // non-jump at 0xFF wraps the PC to 0x00
        imem[8'h00] = 16'hC0FF; imem[8'hFF] = 16'h1234;
        e_req(8'h00); e_iss(16'hC0FF, 8'd0); e_ld(8'hFF);
        e_req(8'hFF); e_iss(16'h1234, 8'd0); e_inc(8'hFF);
        e_req(8'h00); e_iss(16'hB000, 8'd0);
        go("seg_f");
        wait_fetch_done();
        imem[8'h00] = 16'hB000;
        end_seg("seg_f", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the run must never hang
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
